// File: rtl/jtag_bus_bridge.sv
// rtl/jtag_bus_bridge.sv - debug memory port to system bus master bridge
// One debug request becomes one req/gnt bus access, with alignment check and grant timeout.
module jtag_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic        dbg_req_we,
  input  logic [31:0] dbg_req_addr,
  input  logic [31:0] dbg_req_wdata,
  output logic        dbg_resp_valid,
  output logic [31:0] dbg_resp_rdata,
  output logic        dbg_resp_err,
  output logic        m_req,
  input  logic        m_gnt,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign dbg_req_ready = (state == IDLE);

  // The bus-side registers double as the captured request; they are zero outside REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      dbg_resp_valid <= 1'b0;
      dbg_resp_rdata <= '0;
      dbg_resp_err   <= 1'b0;
      m_req          <= 1'b0;
      m_we           <= 1'b0;
      m_addr         <= '0;
      m_wdata        <= '0;
    end else begin
      case (state)
        IDLE: begin
          dbg_resp_valid <= 1'b0;
          if (dbg_req_valid) begin
            if (dbg_req_addr[1:0] != 2'b00) begin
              state          <= RESP;
              dbg_resp_valid <= 1'b1;
              dbg_resp_err   <= 1'b1;
              dbg_resp_rdata <= '0;
            end else begin
              state   <= REQ;
              cnt     <= '0;
              m_req   <= 1'b1;
              m_we    <= dbg_req_we;
              m_addr  <= dbg_req_addr;
              m_wdata <= dbg_req_wdata;
            end
          end
        end

        REQ: begin
          // A grant in the timeout-limit cycle still completes the access.
          if (m_gnt || cnt == CNT_LAST) begin
            state          <= RESP;
            dbg_resp_valid <= 1'b1;
            dbg_resp_err   <= ~m_gnt;
            dbg_resp_rdata <= (m_gnt && !m_we) ? m_rdata : 32'd0;
            m_req          <= 1'b0;
            m_we           <= 1'b0;
            m_addr         <= '0;
            m_wdata        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESP: begin
          state          <= IDLE;
          dbg_resp_valid <= 1'b0;
          dbg_resp_err   <= 1'b0;
          dbg_resp_rdata <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// tb/tb_jtag_bus_bridge.sv - self-checking bench for jtag_bus_bridge
// Transactions are checked against a latency/outcome model derived from grant delay and alignment.
module tb_jtag_bus_bridge;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_we;
  logic [31:0] dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_resp_valid;
  logic [31:0] dbg_resp_rdata;
  logic        dbg_resp_err;
  logic        m_req;
  logic        m_gnt;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int errors = 0;
  int checks = 0;

  jtag_bus_bridge #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .dbg_req_valid  (dbg_req_valid),
    .dbg_req_ready  (dbg_req_ready),
    .dbg_req_we     (dbg_req_we),
    .dbg_req_addr   (dbg_req_addr),
    .dbg_req_wdata  (dbg_req_wdata),
    .dbg_resp_valid (dbg_resp_valid),
    .dbg_resp_rdata (dbg_resp_rdata),
    .dbg_resp_err   (dbg_resp_err),
    .m_req          (m_req),
    .m_gnt          (m_gnt),
    .m_we           (m_we),
    .m_addr         (m_addr),
    .m_wdata        (m_wdata),
    .m_rdata        (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // gdel = number of REQ cycles without grant before the grant cycle
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input int gdel, input logic [31:0] rd);
    int          exp_cyc, exp_mreq, mreq_n, resp_cyc;
    logic        exp_err, got_err, hold_ok;
    logic [31:0] exp_rd, got_rd;

    if (addr[1:0] != 2'b00) begin
      exp_cyc = 1; exp_mreq = 0; exp_err = 1'b1; exp_rd = 32'd0;
    end else if (gdel < T) begin
      exp_cyc = gdel + 2; exp_mreq = gdel + 1; exp_err = 1'b0; exp_rd = we ? 32'd0 : rd;
    end else begin
      exp_cyc = T + 1; exp_mreq = T; exp_err = 1'b1; exp_rd = 32'd0;
    end

    mreq_n = 0; resp_cyc = -1; hold_ok = 1'b1; got_err = 1'b0; got_rd = 32'd0;
    chk({name, ".ready_in"}, 32'(dbg_req_ready), 32'd1);
    dbg_req_valid = 1'b1; dbg_req_we = we; dbg_req_addr = addr; dbg_req_wdata = wd;
    tick;
    dbg_req_valid = 1'b0; dbg_req_addr = $urandom; dbg_req_wdata = $urandom;

    for (int c = 1; c <= 40 && resp_cyc < 0; c++) begin
      if (m_req) begin
        mreq_n++;
        if (m_addr !== addr || m_we !== we || m_wdata !== wd || dbg_req_ready !== 1'b0)
          hold_ok = 1'b0;
        m_gnt   = (mreq_n == gdel + 1);
        m_rdata = m_gnt ? rd : $urandom;
      end else begin
        if (m_addr !== 32'd0 || m_we !== 1'b0 || m_wdata !== 32'd0) hold_ok = 1'b0;
        m_gnt   = 1'($urandom_range(1));
        m_rdata = $urandom;
      end
      if (dbg_resp_valid) begin
        resp_cyc = c; got_err = dbg_resp_err; got_rd = dbg_resp_rdata;
      end else begin
        tick;
      end
    end

    chk({name, ".resp_cycle"}, 32'(resp_cyc), 32'(exp_cyc));
    chk({name, ".mreq_cycles"}, 32'(mreq_n), 32'(exp_mreq));
    chk({name, ".bus_hold"}, 32'(hold_ok), 32'd1);
    chk({name, ".err"}, 32'(got_err), 32'(exp_err));
    chk({name, ".rdata"}, got_rd, exp_rd);
    m_gnt = 1'b0;
    tick;
    chk({name, ".pulse_end"}, 32'(dbg_resp_valid), 32'd0);
    chk({name, ".ready_out"}, 32'(dbg_req_ready), 32'd1);
  endtask

  task automatic reset_mid_access;
    int resp_n;
    resp_n = 0;
    m_gnt = 1'b0;
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 32'h0000_3000; dbg_req_wdata = 32'hCAFE_F00D;
    tick;
    dbg_req_valid = 1'b0;
    tick;
    chk("rstmid.mreq_before", 32'(m_req), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstmid.mreq_after", 32'(m_req), 32'd0);
    chk("rstmid.ready_after", 32'(dbg_req_ready), 32'd1);
    for (int c = 0; c < 8; c++) begin
      if (dbg_resp_valid) resp_n++;
      tick;
    end
    chk("rstmid.no_resp", 32'(resp_n), 32'd0);
  endtask

  task automatic back_to_back;
    int acc[$];
    int resp[$];
    m_gnt = 1'b1; m_rdata = $urandom;
    dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_req_addr = 32'h0000_0100; dbg_req_wdata = 32'h5A5A_A5A5;
    for (int c = 0; c < 16; c++) begin
      if (dbg_resp_valid) begin
        resp.push_back(c);
        chk("b2b.err", 32'(dbg_resp_err), 32'd0);
      end
      if (dbg_req_ready && dbg_req_valid) acc.push_back(c);
      tick;
      if (acc.size() == 3) dbg_req_valid = 1'b0;
    end
    m_gnt = 1'b0;
    chk("b2b.accepts", 32'(acc.size()), 32'd3);
    chk("b2b.responses", 32'(resp.size()), 32'd3);
    for (int i = 0; i < 3 && i < acc.size() && i < resp.size(); i++) begin
      chk("b2b.resp_lat", 32'(resp[i] - acc[i]), 32'd2);
      if (i > 0) chk("b2b.spacing", 32'(acc[i] - acc[i-1]), 32'd3);
    end
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; dbg_req_valid = 1'b0; dbg_req_we = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
    m_gnt = 1'b0; m_rdata = '0;
    repeat (3) tick;
    rst = 1'b0;
    chk("reset.ready", 32'(dbg_req_ready), 32'd1);
    chk("reset.mreq", 32'(m_req), 32'd0);
    chk("reset.resp_valid", 32'(dbg_resp_valid), 32'd0);
    chk("reset.maddr", m_addr, 32'd0);
    chk("reset.rdata", dbg_resp_rdata, 32'd0);

    run_txn("wr_imm", 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0);
    run_txn("rd_wait3", 1'b0, 32'h0000_2004, 32'h0, 3, 32'h1234_5678);
    run_txn("misalign", 1'b0, 32'h0000_2002, 32'h0, 0, 32'h0);
    run_txn("timeout", 1'b0, 32'h0000_4000, 32'h0, 100, 32'h0);
    run_txn("gnt_at_limit", 1'b0, 32'h0000_4000, 32'h0, T - 1, 32'h8765_4321);
    reset_mid_access;
    run_txn("after_rst", 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0BAD_F00D);
    back_to_back;
    tick;

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      run_txn("rand", 1'($urandom_range(1)), a, $urandom, int'($urandom_range(0, 6)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_bus_bridge.md
Name: jtag_bus_bridge

Overview:
- Sits directly downstream of the JTAG debug module's memory port. Converts each single debug memory request into one master transaction on the core's shared system bus (req/grant style).
- Handles the following: arbitration wait, grant timeout, address-alignment checking, and return of read data and error status to the debug module.
- One bridge instance is placed between the debug module and the bus arbiter's debug master slot.

Parameters:
- TIMEOUT_CYCLES, 255: maximum consecutive cycles in REQ without grant before the access is aborted; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  input  1  single clock. The bridge, the debug-side requester and the bus all run on it.
- rst  input  1  synchronous, active-high reset.
- dbg_req_valid  input  1  debug request present.
- dbg_req_ready  output  1  bridge can accept a request; high only in IDLE.
- dbg_req_we  input  1  1 = write, 0 = read.
- dbg_req_addr  input  32  byte address; must be word aligned.
- dbg_req_wdata  input  32  write data.
- dbg_resp_valid  output  1  one-cycle pulse marking a completed request.
- dbg_resp_rdata  output  32  read data; 0 for writes and errors.
- dbg_resp_err  output  1  qualifies dbg_resp_valid; 1 = misaligned or timeout.
- m_req  output  1  bus request to the arbiter.
- m_gnt  input  1  arbiter grant; the access completes in the cycle where m_req and m_gnt are both 1.
- m_we  output  1  bus write enable.
- m_addr  output  32  bus address.
- m_wdata  output  32  bus write data.
- m_rdata  input  32  bus read data; valid in the grant cycle.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State becomes IDLE.
  - All outputs go to 0, except dbg_req_ready, which is 1.
  - Captured address, write data and the counter are cleared.
  - A reset in the middle of an access drops m_req at that edge. No response is produced for the aborted request.
- States: IDLE, REQ, RESP.
- IDLE:
  - dbg_req_ready=1.
  - On dbg_req_valid=1, capture we, addr and wdata.
  - If addr[1:0]!=0: go to RESP with err=1 and rdata=0. No bus activity.
  - Otherwise: go to REQ and clear the counter.
- REQ:
  - m_req=1; m_we, m_addr and m_wdata are driven from the captured registers and held stable for the whole state.
  - dbg_req_ready=0, and new dbg_req_valid is ignored.
  - If m_gnt=1: capture rdata (m_rdata for reads, 0 for writes), set err=0, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: set err=1 and rdata=0, go to RESP. m_req is deasserted on the next cycle.
  - Else: counter+1.
  - A grant arriving in the same cycle as the timeout limit wins: the access completes successfully.
- RESP:
  - dbg_resp_valid=1 for exactly one cycle, with dbg_resp_rdata and dbg_resp_err held from registers; m_req=0.
  - Next state is IDLE. There is no backpressure: the requester must accept the response.
- Outside REQ, m_we, m_addr and m_wdata are 0.
- Latency, for a request accepted at edge 0:
  - Grant in the first REQ cycle: dbg_resp_valid in cycle 2.
  - Misaligned request: response in cycle 1.
  - Timeout: response in cycle 1+TIMEOUT_CYCLES.
- Back-to-back requests: the next request is accepted in the IDLE cycle after RESP, giving a minimum of 3 cycles per access.
- All registered outputs change only on clk rising edges. dbg_req_ready is a decode of state.

Test Plan:
- Aligned write, addr=0x0000_1000, wdata=0xDEAD_BEEF, m_gnt tied 1:
  - m_req/m_we=1 with m_addr=0x1000 and m_wdata=0xDEADBEEF for exactly 1 cycle.
  - dbg_resp_valid pulses in cycle 2 with err=0 and rdata=0.
- Read, addr=0x0000_2004, m_gnt asserted 3 cycles after REQ entry, m_rdata=0x1234_5678 in the grant cycle:
  - m_req is held for 4 cycles with the address stable.
  - Response carries rdata=0x12345678 and err=0.
- Misaligned read, addr=0x0000_2002:
  - m_req is never asserted.
  - dbg_resp_valid arrives in cycle 1 with err=1 and rdata=0.
- Timeout with TIMEOUT_CYCLES=4 and m_gnt held 0:
  - m_req is high for exactly 4 cycles.
  - Response has err=1, then the bridge returns to IDLE.
  - A repeat run with m_gnt=1 in the 4th REQ cycle gives err=0.
- rst=1 in the second REQ cycle:
  - m_req=0 and dbg_req_ready=1 after that edge.
  - No dbg_resp_valid is produced.
  - A following request completes normally.
- dbg_req_valid held high continuously, grant immediate:
  - Requests are accepted only in IDLE, every 3 cycles.
  - Each request yields exactly one response pulse.
